tcp_vlg_rx_ctl: RTL and testbench

Receive-side payload controller for the TCP engine; counterpart of the transmit control path. It accepts the payload byte stream from the engine's RX parser, checks each segment's sequence number against the local acknowledge number, and stages the bytes in a buffer. Only segments that are in order and complete are committed. The block delivers committed bytes to the user with a valid/ready handshake, advertises the free space as the receive window, and asks the engine to send ACKs (delayed or immediate).

---
 rtl/tcp_vlg_rx_ctl.sv | 154 +++++++++++++++
 tb/tb_tcp_vlg_rx_ctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_rx_ctl.sv
// Receive payload controller: sequence check, staging buffer with commit-on-complete,
// show-ahead user delivery, receive window and delayed/immediate ACK requests.
module tcp_vlg_rx_ctl #(
   parameter int RAM_DEPTH = 10,
   parameter int ACK_BYTES = 1460,
   parameter int ACK_TICKS = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic [31:0] loc_ack_init,
   input  logic        strm_val,
   input  logic        strm_sof,
   input  logic        strm_eof,
   input  logic [7:0]  strm_dat,
   input  logic [31:0] strm_seq,
   input  logic [15:0] strm_len,
   input  logic        strm_err,
   output logic        dat_val,
   output logic [7:0]  dat,
   input  logic        dat_rdy,
   output logic [31:0] loc_ack,
   output logic [15:0] wnd,
   output logic        ack_req,
   input  logic        ack_sent
);
   localparam int DEPTH = 1 << RAM_DEPTH;
   localparam logic [15:0] WND_RST = (DEPTH - 1 > 65535) ? 16'hFFFF : 16'(DEPTH - 1);
   localparam logic [RAM_DEPTH-1:0] PTR_ONE = {{(RAM_DEPTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
   state_t state;

   logic [7:0]           ram [DEPTH];
   logic [RAM_DEPTH-1:0] rd, wr_commit, wr_tmp, rd_nxt, free, wr_addr;
   logic [15:0]          len_lat;
   logic [16:0]          cnt, cnt_inc, commit_cnt;
   logic signed [31:0]   seq_diff;
   logic [31:0]          ack_cnt, ack_cnt_nxt, ack_tmr, tmr_nxt;
   logic                 tmr_run, run_nxt, imm_ack, imm_nxt, ack_req_nxt;
   logic                 sof, accept, set_imm, wr_en, commit, xfer;

   function automatic logic [15:0] sat_wnd(input logic [RAM_DEPTH-1:0] f);
      logic [31:0] f32;
      f32 = 32'(f);
      return (f32 > 32'd65535) ? 16'hFFFF : f32[15:0];
   endfunction

   // free is 2^RAM_DEPTH-1 minus occupancy; the bitwise complement gives exactly that mod 2^RAM_DEPTH
   assign free    = ~(wr_commit - rd);
   assign xfer    = dat_val && dat_rdy;
   assign rd_nxt  = rd + {{(RAM_DEPTH-1){1'b0}}, xfer};
   assign cnt_inc = (&cnt) ? cnt : cnt + 17'd1;

   always_comb begin
      seq_diff   = signed'(strm_seq - loc_ack);
      sof        = strm_val && strm_sof;
      accept     = sof && (seq_diff == 0) && (32'(strm_len) <= 32'(free));
      set_imm    = sof && (seq_diff != 0);
      wr_en      = 1'b0;
      wr_addr    = wr_tmp;
      commit     = 1'b0;
      commit_cnt = cnt_inc;
      if (accept) begin
         wr_en      = 1'b1;
         wr_addr    = wr_commit;
         commit     = strm_eof && !strm_err && (strm_len == 16'd1);
         commit_cnt = 17'd1;
      end else if (!sof && strm_val && state == RECV) begin
         // bytes past the latched length are never stored, so they cannot overrun unread data
         wr_en  = (cnt < {1'b0, len_lat});
         commit = strm_eof && !strm_err && (cnt_inc == {1'b0, len_lat});
      end
   end

   always_comb begin
      ack_cnt_nxt = ack_sent ? 32'd0 : ack_cnt;
      if (commit) ack_cnt_nxt = ack_cnt_nxt + 32'(commit_cnt);
      run_nxt = tmr_run;
      tmr_nxt = ack_tmr;
      if (commit && (ack_sent || !tmr_run)) begin
         run_nxt = 1'b1;
         tmr_nxt = 32'd0;
      end else if (ack_sent) begin
         run_nxt = 1'b0;
         tmr_nxt = 32'd0;
      end else if (tmr_run && ack_tmr != 32'(ACK_TICKS - 1)) begin
         tmr_nxt = ack_tmr + 32'd1;
      end
      imm_nxt     = (imm_ack && !ack_sent) || set_imm;
      ack_req_nxt = (ack_req && !ack_sent) || imm_nxt ||
                    (ack_cnt_nxt >= 32'(ACK_BYTES)) ||
                    (run_nxt && tmr_nxt == 32'(ACK_TICKS - 1));
   end

   always_ff @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= strm_dat;
   end

   always_ff @(posedge clk) begin
      if (rst || init) begin
         state     <= IDLE;
         rd        <= '0;
         wr_commit <= '0;
         wr_tmp    <= '0;
         cnt       <= '0;
         len_lat   <= '0;
         ack_cnt   <= '0;
         ack_tmr   <= '0;
         tmr_run   <= 1'b0;
         imm_ack   <= 1'b0;
         ack_req   <= 1'b0;
         dat_val   <= 1'b0;
         dat       <= '0;
         wnd       <= WND_RST;
         loc_ack   <= rst ? 32'd0 : loc_ack_init;
      end else begin
         // output stage compares against pre-commit wr_commit: delivery trails the eof by 2 cycles
         rd      <= rd_nxt;
         dat_val <= (rd_nxt != wr_commit);
         dat     <= ram[rd_nxt];
         wnd     <= sat_wnd(free);
         ack_cnt <= ack_cnt_nxt;
         ack_tmr <= tmr_nxt;
         tmr_run <= run_nxt;
         imm_ack <= imm_nxt;
         ack_req <= ack_req_nxt;
         if (commit) begin
            wr_commit <= wr_addr + PTR_ONE;
            loc_ack   <= loc_ack + 32'(commit_cnt);
         end
         if (sof) begin
            len_lat <= strm_len;
            cnt     <= 17'd1;
            wr_tmp  <= wr_commit + PTR_ONE;
            if (strm_eof)    state <= IDLE;
            else if (accept) state <= RECV;
            else             state <= DROP;
         end else if (strm_val) begin
            if (state == RECV) begin
               cnt <= cnt_inc;
               if (strm_eof) begin
                  wr_tmp <= commit ? wr_tmp + PTR_ONE : wr_commit;
                  state  <= IDLE;
               end else begin
                  wr_tmp <= wr_tmp + PTR_ONE;
               end
            end else if (state == DROP && strm_eof) begin
               state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_tcp_vlg_rx_ctl.sv
// Bench for tcp_vlg_rx_ctl: segment-level reference model (expected byte queue,
// ack number, buffer occupancy) driven with directed and randomized segments.
module tb_tcp_vlg_rx_ctl;
   localparam int TICKS = 200;
   localparam int BYTES = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init = 1'b0;
   logic [31:0] loc_ack_init = '0;
   logic        strm_val = 1'b0, strm_sof = 1'b0, strm_eof = 1'b0, strm_err = 1'b0;
   logic [7:0]  strm_dat = '0;
   logic [31:0] strm_seq = '0;
   logic [15:0] strm_len = '0;
   logic        dat_val, dat_rdy = 1'b0, ack_req, ack_sent = 1'b0;
   logic [7:0]  dat;
   logic [31:0] loc_ack;
   logic [15:0] wnd;

   int          n_total = 0, n_pass = 0, n_fail = 0;
   int          cyc = 0, eof_cyc = 0, committed = 0, rd_count = 0;
   logic [31:0] m_ack = '0;
   logic [7:0]  exp_q [$];
   logic        req_after_sof = 1'b0;
   bit          rand_rdy = 1'b0;

   tcp_vlg_rx_ctl #(.RAM_DEPTH(10), .ACK_BYTES(BYTES), .ACK_TICKS(TICKS)) dut (
      .clk(clk), .rst(rst), .init(init), .loc_ack_init(loc_ack_init),
      .strm_val(strm_val), .strm_sof(strm_sof), .strm_eof(strm_eof), .strm_dat(strm_dat),
      .strm_seq(strm_seq), .strm_len(strm_len), .strm_err(strm_err),
      .dat_val(dat_val), .dat(dat), .dat_rdy(dat_rdy),
      .loc_ack(loc_ack), .wnd(wnd), .ack_req(ack_req), .ack_sent(ack_sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // every user transfer must match the next byte the model committed
   always @(negedge clk) begin
      if (!rst && dat_val && dat_rdy) begin
         logic [8:0] e;
         e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
         check("dat", 32'({1'b0, dat}), 32'(e));
         rd_count++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) dat_rdy = 1'($urandom);
   endtask

   task automatic idle();
      strm_val = 1'b0; strm_sof = 1'b0; strm_eof = 1'b0; strm_err = 1'b0;
   endtask

   task automatic ack_pulse();
      ack_sent = 1'b1;
      tick();
      ack_sent = 1'b0;
   endtask

   task automatic send_seg(input logic [31:0] seq, input int len, input int nsend,
                           input bit err, input bit noeof, input int gap);
      logic [7:0] b [$];
      int fr;
      bit acc;
      fr  = 1023 - (committed - rd_count);
      acc = (seq == m_ack) && (len <= fr) && (nsend == len) && !err && !noeof;
      for (int i = 0; i < nsend; i++) begin
         strm_val = 1'b1;
         strm_sof = (i == 0);
         strm_eof = (i == nsend - 1) && !noeof;
         strm_dat = 8'($urandom);
         strm_seq = (i == 0) ? seq : $urandom;
         strm_len = (i == 0) ? 16'(len) : 16'($urandom);
         strm_err = strm_eof ? err : 1'($urandom);
         b.push_back(strm_dat);
         if (strm_eof) eof_cyc = cyc;
         tick();
         if (i == 0) req_after_sof = ack_req;
         if (i != nsend - 1 && gap > 0)
            repeat ($urandom_range(0, gap)) begin idle(); tick(); end
      end
      idle();
      if (acc) begin
         foreach (b[k]) exp_q.push_back(b[k]);
         m_ack     += 32'(len);
         committed += len;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_rdy = 1'b0;
      dat_rdy  = 1'b1;
      while ((exp_q.size() != 0 || dat_val) && n < 3000) begin tick(); n++; end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
   endtask

   task automatic do_init(input logic [31:0] v);
      drain();
      init = 1'b1;
      loc_ack_init = v;
      tick();
      init = 1'b0;
      m_ack = v; committed = 0; rd_count = 0;
      exp_q.delete();
      check("init_loc_ack", loc_ack, v);
   endtask

   initial begin
      logic [31:0] s4;
      int len, kind;
      repeat (3) tick();
      check("rst_dat_val", 32'(dat_val), 32'd0);
      check("rst_dat", 32'(dat), 32'd0);
      check("rst_ack_req", 32'(ack_req), 32'd0);
      check("rst_wnd", 32'(wnd), 32'd1023);
      check("rst_loc_ack", loc_ack, 32'd0);
      rst = 1'b0;
      tick();

      // in-order segment delivered
      do_init(32'h1000);
      dat_rdy = 1'b1;
      send_seg(32'h1000, 100, 100, 1'b0, 1'b0, 0);
      check("t1_loc_ack", loc_ack, 32'h1064);
      drain();
      check("t1_wnd", 32'(wnd), 32'd1023);

      // old and future segments: dropped, immediate ACK
      ack_pulse();
      check("t2_req_clear0", 32'(ack_req), 32'd0);
      send_seg(32'h0F00, 20, 20, 1'b0, 1'b0, 0);
      check("t2_req_after_sof", 32'(req_after_sof), 32'd1);
      check("t2_loc_ack", loc_ack, 32'h1064);
      ack_pulse();
      check("t2_req_cleared", 32'(ack_req), 32'd0);
      send_seg(32'h2000, 20, 20, 1'b0, 1'b0, 1);
      check("t2_future_req", 32'(req_after_sof), 32'd1);
      ack_pulse();

      // errored, short, long and unterminated segments discarded; retry delivered
      send_seg(m_ack, 100, 100, 1'b1, 1'b0, 1);
      check("t3_err_loc_ack", loc_ack, 32'h1064);
      send_seg(m_ack, 100, 50, 1'b0, 1'b0, 0);
      send_seg(m_ack, 100, 101, 1'b0, 1'b0, 0);
      send_seg(m_ack, 100, 40, 1'b0, 1'b1, 0);
      check("t3_bad_loc_ack", loc_ack, 32'h1064);
      send_seg(m_ack, 100, 100, 1'b0, 1'b0, 1);
      check("t3_good_loc_ack", loc_ack, 32'h10C8);
      send_seg(m_ack, 1, 1, 1'b0, 1'b0, 0);
      check("t3_single_loc_ack", loc_ack, 32'h10C9);
      drain();

      // full buffer: window shrinks and an oversized segment is dropped
      dat_rdy = 1'b0;
      repeat (10) send_seg(m_ack, 100, 100, 1'b0, 1'b0, 0);
      repeat (2) tick();
      check("t4_wnd", 32'(wnd), 32'd23);
      s4 = m_ack;
      send_seg(s4, 100, 100, 1'b0, 1'b0, 0);
      check("t4_drop_loc_ack", loc_ack, s4);
      check("t4_dat_val_held", 32'(dat_val), 32'd1);
      drain();
      check("t4_wnd_empty", 32'(wnd), 32'd1023);
      send_seg(s4, 100, 100, 1'b0, 1'b0, 1);
      check("t4_retry_loc_ack", loc_ack, s4 + 32'd100);
      drain();

      // delayed ACK by timer, then by byte count
      ack_pulse();
      send_seg(m_ack, 10, 10, 1'b0, 1'b0, 0);
      check("t5_req_early", 32'(ack_req), 32'd0);
      while (!ack_req && (cyc - eof_cyc) < 2 * TICKS) tick();
      check("t5_tmr_delay", 32'(cyc - eof_cyc), 32'(TICKS));
      ack_pulse();
      check("t5_req_cleared", 32'(ack_req), 32'd0);
      send_seg(m_ack, BYTES, BYTES, 1'b0, 1'b0, 0);
      check("t5_bytes_req_sof", 32'(req_after_sof), 32'd0);
      check("t5_bytes_req", 32'(ack_req), 32'd1);
      ack_pulse();
      send_seg(m_ack, BYTES, BYTES, 1'b0, 1'b0, 0);
      check("t5_bytes_req2", 32'(ack_req), 32'd1);
      drain();

      // sequence wrap
      do_init(32'hFFFF_FFF0);
      send_seg(32'hFFFF_FFF0, 32, 32, 1'b0, 1'b0, 1);
      check("t6_wrap_loc_ack", loc_ack, 32'h0000_0010);
      ack_pulse();
      send_seg(32'hFFFF_FFF8, 8, 8, 1'b0, 1'b0, 0);
      check("t6_old_req", 32'(req_after_sof), 32'd1);
      send_seg(32'h0000_0010, 20, 20, 1'b0, 1'b0, 0);
      check("t6_next_loc_ack", loc_ack, 32'h0000_0024);
      drain();
      check("t6_wnd", 32'(wnd), 32'd1023);

      // randomized traffic with random user backpressure
      rand_rdy = 1'b1;
      for (int s = 0; s < 60; s++) begin
         len  = $urandom_range(2, 150);
         kind = $urandom_range(0, 9);
         case (kind)
            0:       send_seg(m_ack, len, len, 1'b1, 1'b0, 2);
            1:       send_seg(m_ack - 32'($urandom_range(1, 5000)), len, len, 1'b0, 1'b0, 2);
            2:       send_seg(m_ack + 32'($urandom_range(1, 5000)), len, len, 1'b0, 1'b0, 2);
            3:       send_seg(m_ack, len, $urandom_range(1, len - 1), 1'b0, 1'b0, 2);
            4:       send_seg(m_ack, len, $urandom_range(1, len), 1'b0, 1'b1, 2);
            5:       send_seg(m_ack, 1, 1, 1'b0, 1'b0, 0);
            default: send_seg(m_ack, len, len, 1'b0, 1'b0, 2);
         endcase
         if ($urandom_range(0, 3) == 0) ack_pulse();
      end
      send_seg(m_ack, 50, 50, 1'b0, 1'b0, 0);
      drain();
      check("rand_loc_ack", loc_ack, m_ack);
      check("rand_wnd", 32'(wnd), 32'd1023);
      check("rand_dat_val", 32'(dat_val), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
